// File: rtl/fp_conv_arbiter.sv
// Round-robin arbiter sharing one int->fp / fp->int converter pair between two requesters.
// Operands are captured on grant; results are registered and flagged with a done pulse.
module fp_conv_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        op0,
  input  logic        op1,
  input  logic [12:0] din0,
  input  logic [12:0] din1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [12:0] dout,
  output logic        over,
  output logic        under,
  output logic        busy,
  output logic [15:0] conv_cnt
);

  typedef enum logic [1:0] {StIdle, StConv, StResp} state_e;

  state_e      state_q;
  logic        last_q;
  logic        owner_q;
  logic        op_q;
  logic [12:0] din_q;
  logic [12:0] dout_q;
  logic        over_q;
  logic        under_q;
  logic [1:0]  gnt_q;
  logic [1:0]  done_q;
  logic        busy_q;
  logic [15:0] cnt_q;

  logic        win;
  logic [9:0]  f2i;
  logic [12:0] res_dout;
  logic        res_ov;
  logic        res_un;

  // Zero has no normalized encoding; it maps to the all-zero word.
  function automatic logic [12:0] int_to_fp(input logic [7:0] v);
    logic [7:0] mag;
    logic [3:0] e;
    logic [7:0] f;
    mag = v[7] ? (8'd0 - v) : v;
    e   = 4'd0;
    f   = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (mag[i]) begin
        e = 4'(i + 1);
        f = mag << (7 - i);
      end
    end
    return (mag == 8'd0) ? 13'd0 : {v[7], e, f};
  endfunction

  // Returns {over, under, integer}; truncates toward zero, saturates on overflow.
  function automatic logic [9:0] fp_to_int(input logic [12:0] f);
    logic [8:0] mag;
    logic [7:0] integ;
    logic       ov;
    logic       un;
    mag = 9'd0;
    ov  = 1'b0;
    un  = 1'b0;
    if (f[7:0] != 8'd0) begin
      if (f[11:8] > 4'd8) begin
        ov = 1'b1;
      end else begin
        mag = {1'b0, f[7:0]} >> (4'd8 - f[11:8]);
        un  = (f[11:8] == 4'd0);
        ov  = f[12] ? (mag > 9'd128) : (mag > 9'd127);
      end
    end
    if (ov) integ = f[12] ? 8'h80 : 8'h7F;
    else    integ = f[12] ? (8'd0 - mag[7:0]) : mag[7:0];
    return {ov, un, integ};
  endfunction

  assign win = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    f2i = fp_to_int(din_q);
    if (op_q) begin
      res_dout = {{5{f2i[7]}}, f2i[7:0]};
      res_ov   = f2i[9];
      res_un   = f2i[8];
    end else begin
      res_dout = int_to_fp(din_q[7:0]);
      res_ov   = 1'b0;
      res_un   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      op_q    <= 1'b0;
      din_q   <= 13'd0;
      dout_q  <= 13'd0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      gnt_q  <= 2'b00;
      done_q <= 2'b00;
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            owner_q <= win;
            op_q    <= win ? op1 : op0;
            din_q   <= win ? din1 : din0;
            gnt_q   <= win ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            state_q <= StConv;
          end
        end
        StConv: begin
          dout_q  <= res_dout;
          over_q  <= res_ov;
          under_q <= res_un;
          done_q  <= owner_q ? 2'b10 : 2'b01;
          state_q <= StResp;
        end
        StResp: begin
          last_q  <= owner_q;
          cnt_q   <= cnt_q + 16'd1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign done0    = done_q[0];
  assign done1    = done_q[1];
  assign dout     = dout_q;
  assign over     = over_q;
  assign under    = under_q;
  assign busy     = busy_q;
  assign conv_cnt = cnt_q;

endmodule
